// File: rtl/psum_row_acc_if.sv
// Channel-side bundle of one PSUM accumulator: arbiter flag, MAC product
// stream in, and the drain stream towards the global buffer.
interface psum_row_acc_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 16,
    parameter int PSUM_WIDTH = 24
);
    logic                         ARBPSUM_fnh;
    logic                         PSUMARB_empty;
    logic                         MACPSUM_Val;
    logic                         MACPSUM_Rdy;
    logic [ADDR_WIDTH-1:0]        MACPSUM_Addr;
    logic signed [DATA_WIDTH-1:0] MACPSUM_Dat;
    logic                         MACPSUM_Lst;
    logic                         PSUMGB_Val;
    logic                         PSUMGB_Rdy;
    logic [ADDR_WIDTH-1:0]        PSUMGB_Addr;
    logic signed [PSUM_WIDTH-1:0] PSUMGB_Dat;

    // master is the surrounding fabric (arbiter, MACs, global buffer)
    modport master (
        output ARBPSUM_fnh, MACPSUM_Val, MACPSUM_Addr, MACPSUM_Dat, MACPSUM_Lst, PSUMGB_Rdy,
        input  PSUMARB_empty, MACPSUM_Rdy, PSUMGB_Val, PSUMGB_Addr, PSUMGB_Dat
    );

    modport slave (
        input  ARBPSUM_fnh, MACPSUM_Val, MACPSUM_Addr, MACPSUM_Dat, MACPSUM_Lst, PSUMGB_Rdy,
        output PSUMARB_empty, MACPSUM_Rdy, PSUMGB_Val, PSUMGB_Addr, PSUMGB_Dat
    );
endinterface

// File: rtl/psum_row_acc.sv
// Per-channel partial-sum row accumulator: sums MAC row products into a
// LENROW-entry buffer with saturation, then drains it to the global buffer.
module psum_row_acc #(
    parameter int LENROW      = 16,
    parameter int DATA_WIDTH  = 16,
    parameter int PSUM_WIDTH  = 24,
    parameter int NUM_CONTRIB = 9
) (
    input  logic          clk,
    input  logic          rst_n,
    psum_row_acc_if.slave bus
);
    localparam int ADDR_WIDTH = $clog2(LENROW);
    localparam int CNT_WIDTH  = 4;

    localparam logic [CNT_WIDTH-1:0]  DONE_FULL = CNT_WIDTH'(NUM_CONTRIB);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(LENROW - 1);
    localparam logic [PSUM_WIDTH-1:0] PSUM_MAX  = {1'b0, {(PSUM_WIDTH-1){1'b1}}};
    localparam logic [PSUM_WIDTH-1:0] PSUM_MIN  = {1'b1, {(PSUM_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [PSUM_WIDTH-1:0]   row_buf [LENROW];
    logic [CNT_WIDTH-1:0]    done_cnt;
    logic [CNT_WIDTH-1:0]    done_cnt_nxt;
    logic [ADDR_WIDTH-1:0]   out_cnt;
    logic                    mac_fire;
    logic                    lst_fire;
    logic                    gb_fire;
    logic                    row_done;
    logic [PSUM_WIDTH-1:0]   cur_val;
    logic [PSUM_WIDTH:0]     sum_wide;
    logic [PSUM_WIDTH-1:0]   sum_sat;

    assign mac_fire = bus.MACPSUM_Val && (state == ACC);
    assign lst_fire = mac_fire && bus.MACPSUM_Lst;
    assign gb_fire  = bus.PSUMGB_Rdy && (state == OUT);

    // Extra Lst beats after the row is complete must not push the count past full.
    always_comb begin
        done_cnt_nxt = done_cnt;
        if (lst_fire && (done_cnt < DONE_FULL)) begin
            done_cnt_nxt = done_cnt + 1'b1;
        end
    end

    // Counting the beat accepted on this edge lets the close happen without a bubble.
    assign row_done = (done_cnt_nxt == DONE_FULL);

    always_comb begin
        cur_val  = row_buf[bus.MACPSUM_Addr];
        sum_wide = {cur_val[PSUM_WIDTH-1], cur_val}
                 + {{(PSUM_WIDTH + 1 - DATA_WIDTH){bus.MACPSUM_Dat[DATA_WIDTH-1]}}, bus.MACPSUM_Dat};
        if (sum_wide[PSUM_WIDTH] != sum_wide[PSUM_WIDTH-1]) begin
            sum_sat = sum_wide[PSUM_WIDTH] ? PSUM_MIN : PSUM_MAX;
        end else begin
            sum_sat = sum_wide[PSUM_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt         = state;
        bus.PSUMARB_empty = 1'b0;
        bus.MACPSUM_Rdy   = 1'b0;
        bus.PSUMGB_Val    = 1'b0;
        bus.PSUMGB_Addr   = '0;
        bus.PSUMGB_Dat    = '0;
        case (state)
            IDLE: begin
                bus.PSUMARB_empty = 1'b1;
                if (!bus.ARBPSUM_fnh) begin
                    state_nxt = ACC;
                end
            end
            ACC: begin
                bus.MACPSUM_Rdy = 1'b1;
                if (bus.ARBPSUM_fnh && row_done) begin
                    state_nxt = OUT;
                end
            end
            OUT: begin
                bus.PSUMGB_Val  = 1'b1;
                bus.PSUMGB_Addr = out_cnt;
                bus.PSUMGB_Dat  = row_buf[out_cnt];
                if (gb_fire && (out_cnt == LAST_ADDR)) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Draining zeroes each entry as it leaves, so the next row starts clean.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LENROW; i++) begin
                row_buf[i] <= '0;
            end
        end else if (mac_fire) begin
            row_buf[bus.MACPSUM_Addr] <= sum_sat;
        end else if (gb_fire) begin
            row_buf[out_cnt] <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_cnt <= '0;
            out_cnt  <= '0;
        end else begin
            if ((state_nxt == IDLE) && (state != IDLE)) begin
                done_cnt <= '0;
            end else begin
                done_cnt <= done_cnt_nxt;
            end
            if (gb_fire) begin
                out_cnt <= (out_cnt == LAST_ADDR) ? '0 : out_cnt + 1'b1;
            end
        end
    end

    a_phase_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot({bus.PSUMARB_empty, bus.MACPSUM_Rdy, bus.PSUMGB_Val}));

    a_drain_hold: assert property (@(posedge clk) disable iff (!rst_n)
        (bus.PSUMGB_Val && !bus.PSUMGB_Rdy) |=> ($stable(bus.PSUMGB_Addr) && $stable(bus.PSUMGB_Dat)));

    a_done_bound: assert property (@(posedge clk) disable iff (!rst_n)
        done_cnt <= DONE_FULL);
endmodule

// File: tb/tb_psum_row_acc.sv
// Directed bench for psum_row_acc with a row-level reference model that is
// compared against the DUT outputs on every falling edge.
module tb_psum_row_acc;
    localparam int LENROW      = 16;
    localparam int DATA_WIDTH  = 16;
    localparam int PSUM_WIDTH  = 24;
    localparam int NUM_CONTRIB = 9;
    localparam int PSUM_MAX    = 8388607;
    localparam int PSUM_MIN    = -8388608;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int errors = 0;
    int checks = 0;
    int got     [LENROW];
    int exp_row [LENROW];

    int m_buf [LENROW];
    int m_phase;
    int m_done;
    int m_addr;

    psum_row_acc_if #(.ADDR_WIDTH(4), .DATA_WIDTH(DATA_WIDTH), .PSUM_WIDTH(PSUM_WIDTH)) bus ();

    psum_row_acc #(
        .LENROW(LENROW), .DATA_WIDTH(DATA_WIDTH),
        .PSUM_WIDTH(PSUM_WIDTH), .NUM_CONTRIB(NUM_CONTRIB)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic signed [31:0] actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, required %0d", name, actual, expected);
        end
    endtask

    function automatic int clamp(input longint v);
        if (v > PSUM_MAX) return PSUM_MAX;
        if (v < PSUM_MIN) return PSUM_MIN;
        return int'(v);
    endfunction

    // Model phases: 0 = channel empty, 1 = accumulating, 2 = draining.
    always @(negedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < LENROW; i++) m_buf[i] = 0;
            m_phase = 0;
            m_done  = 0;
            m_addr  = 0;
        end else begin
            check_output("empty", bus.PSUMARB_empty, int'(m_phase == 0));
            check_output("mac_rdy", bus.MACPSUM_Rdy, int'(m_phase == 1));
            check_output("gb_val", bus.PSUMGB_Val, int'(m_phase == 2));
            if (m_phase == 2) begin
                check_output("gb_addr", bus.PSUMGB_Addr, m_addr);
                check_output("gb_dat", $signed(bus.PSUMGB_Dat), m_buf[m_addr]);
            end
            case (m_phase)
                0: if (!bus.ARBPSUM_fnh) m_phase = 1;
                1: begin
                    if (bus.MACPSUM_Val) begin
                        m_buf[bus.MACPSUM_Addr] = clamp(longint'(m_buf[bus.MACPSUM_Addr])
                                                      + longint'($signed(bus.MACPSUM_Dat)));
                        if (bus.MACPSUM_Lst && m_done < NUM_CONTRIB) m_done++;
                    end
                    if (bus.ARBPSUM_fnh && m_done == NUM_CONTRIB) begin
                        m_phase = 2;
                        m_addr  = 0;
                    end
                end
                2: if (bus.PSUMGB_Rdy) begin
                    m_buf[m_addr] = 0;
                    if (m_addr == LENROW - 1) begin
                        m_phase = 0;
                        m_done  = 0;
                        m_addr  = 0;
                    end else begin
                        m_addr++;
                    end
                end
                default: m_phase = 0;
            endcase
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input int addr, input int dat, input bit lst);
        bus.MACPSUM_Val  = 1'b1;
        bus.MACPSUM_Addr = 4'(addr);
        bus.MACPSUM_Dat  = 16'(dat);
        bus.MACPSUM_Lst  = lst;
        tick();
        bus.MACPSUM_Val  = 1'b0;
        bus.MACPSUM_Lst  = 1'b0;
    endtask

    task automatic open_channel();
        bus.ARBPSUM_fnh = 1'b0;
        tick();
        check_output("open_rdy", bus.MACPSUM_Rdy, 1);
        check_output("open_empty", bus.PSUMARB_empty, 0);
    endtask

    task automatic close_channel();
        bus.ARBPSUM_fnh = 1'b1;
        tick();
        check_output("close_gb_val", bus.PSUMGB_Val, 1);
    endtask

    // bp=1 drives the global-buffer ready as 1,0,0,1 repeating.
    task automatic drain(input bit bp);
        int n = 0;
        int k = 0;
        for (int a = 0; a < LENROW; a++) got[a] = 0;
        while (n < LENROW && k < 200) begin
            bus.PSUMGB_Rdy = bp ? ((k % 4 == 0) || (k % 4 == 3)) : 1'b1;
            if (bus.PSUMGB_Val && bus.PSUMGB_Rdy) begin
                check_output("drain_order", bus.PSUMGB_Addr, n);
                got[bus.PSUMGB_Addr] = $signed(bus.PSUMGB_Dat);
                n++;
            end
            tick();
            k++;
        end
        check_output("drain_beats", n, LENROW);
        check_output("empty_after_drain", bus.PSUMARB_empty, 1);
        bus.PSUMGB_Rdy = 1'b1;
    endtask

    task automatic check_row(input string name);
        for (int a = 0; a < LENROW; a++) check_output(name, got[a], exp_row[a]);
    endtask

    task automatic check_reset_outputs();
        check_output("rst_empty", bus.PSUMARB_empty, 1);
        check_output("rst_rdy", bus.MACPSUM_Rdy, 0);
        check_output("rst_gb_val", bus.PSUMGB_Val, 0);
        check_output("rst_gb_addr", bus.PSUMGB_Addr, 0);
        check_output("rst_gb_dat", $signed(bus.PSUMGB_Dat), 0);
    endtask

    task automatic saturation_row(input int dat, input int expected);
        open_channel();
        repeat (300) apply_stimulus(3, dat, 1'b0);
        repeat (NUM_CONTRIB) apply_stimulus(0, 0, 1'b1);
        close_channel();
        drain(1'b0);
        for (int a = 0; a < LENROW; a++) exp_row[a] = 0;
        exp_row[3] = expected;
        check_row("saturation");
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: time limit reached, got running, required finished");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        bus.ARBPSUM_fnh  = 1'b1;
        bus.MACPSUM_Val  = 1'b0;
        bus.MACPSUM_Addr = '0;
        bus.MACPSUM_Dat  = '0;
        bus.MACPSUM_Lst  = 1'b0;
        bus.PSUMGB_Rdy   = 1'b1;
        #2;
        check_reset_outputs();
        tick();
        rst_n = 1'b1;
        tick();
        check_output("idle_hold", bus.PSUMARB_empty, 1);

        $display("[TB] single row");
        open_channel();
        for (int r = 0; r < NUM_CONTRIB; r++)
            for (int a = 0; a < LENROW; a++) apply_stimulus(a, 1, a == LENROW - 1);
        close_channel();
        drain(1'b0);
        for (int a = 0; a < LENROW; a++) exp_row[a] = 9;
        check_row("single_row");

        $display("[TB] reset during accumulation");
        open_channel();
        apply_stimulus(2, 5, 1'b0);
        apply_stimulus(3, 6, 1'b1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        bus.ARBPSUM_fnh = 1'b1;
        tick();
        rst_n = 1'b1;
        tick();

        $display("[TB] saturation");
        saturation_row(32'h7FFF, PSUM_MAX);
        saturation_row(32'h8000, PSUM_MIN);

        $display("[TB] fnh late");
        open_channel();
        for (int k = 0; k < NUM_CONTRIB; k++) apply_stimulus(k, k + 1, 1'b1);
        repeat (3) tick();
        check_output("late_gb_val", bus.PSUMGB_Val, 0);
        check_output("late_rdy", bus.MACPSUM_Rdy, 1);
        close_channel();
        drain(1'b0);
        for (int a = 0; a < LENROW; a++) exp_row[a] = (a < NUM_CONTRIB) ? a + 1 : 0;
        check_row("fnh_late");

        $display("[TB] fnh early");
        open_channel();
        for (int k = 0; k < 5; k++) apply_stimulus(k % 4, (k % 2 == 1) ? -50 : 100, 1'b1);
        bus.ARBPSUM_fnh = 1'b1;
        repeat (3) tick();
        check_output("early_gb_val", bus.PSUMGB_Val, 0);
        check_output("early_rdy", bus.MACPSUM_Rdy, 1);
        for (int k = 5; k < 8; k++) apply_stimulus(k % 4, (k % 2 == 1) ? -50 : 100, 1'b1);
        check_output("early_gb_val_8", bus.PSUMGB_Val, 0);
        apply_stimulus(0, 100, 1'b1);
        check_output("early_gb_val_9", bus.PSUMGB_Val, 1);
        drain(1'b0);
        for (int a = 0; a < LENROW; a++) exp_row[a] = 0;
        exp_row[0] = 300;
        exp_row[1] = -100;
        exp_row[2] = 200;
        exp_row[3] = -100;
        check_row("fnh_early");

        $display("[TB] backpressure with beats offered while draining");
        open_channel();
        for (int r = 0; r < NUM_CONTRIB; r++)
            for (int a = 0; a < LENROW; a++) apply_stimulus(a, a + 1, a == LENROW - 1);
        close_channel();
        bus.MACPSUM_Val  = 1'b1;
        bus.MACPSUM_Addr = 4'd7;
        bus.MACPSUM_Dat  = 16'd500;
        bus.MACPSUM_Lst  = 1'b1;
        drain(1'b1);
        for (int a = 0; a < LENROW; a++) exp_row[a] = 9 * (a + 1);
        check_row("backpressure");
        repeat (2) tick();
        check_output("idle_guard_rdy", bus.MACPSUM_Rdy, 0);
        check_output("idle_guard_empty", bus.PSUMARB_empty, 1);
        bus.MACPSUM_Val = 1'b0;
        bus.MACPSUM_Lst = 1'b0;

        $display("[TB] back-to-back row");
        open_channel();
        for (int k = 0; k < NUM_CONTRIB; k++) apply_stimulus(k, 1, 1'b1);
        close_channel();
        drain(1'b0);
        for (int a = 0; a < LENROW; a++) exp_row[a] = (a < NUM_CONTRIB) ? 1 : 0;
        check_row("no_residue");

        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
